pipelined_control_unit: RTL and testbench
=========================================

Name: pipelined_control_unit

Overview:
Registered decode/control stage for the RISC core, successor to the single-cycle combinational decoder. Decodes one opcode per cycle into a control bundle registered into the ID/EX boundary. Sequences the two-word LDM instruction, whose second fetched word is an immediate, via a small FSM. Honours stall and flush from the hazard/branch logic.

Parameters:
OPC_W, 5, opcode width (>=5); alu_op width equals OPC_W.
LDM_OPC, 5'b00001, opcode of two-word load-immediate.
ST_OPC, 5'b00010, store opcode (mem_wr).
LD_OPC, 5'b00101, memory load opcode (mem_rd, reg_wr).
ALU1_OPC, 5'b00011, reg-writing ALU opcode.
ALU2_OPC, 5'b00100, reg-writing ALU opcode.
NOP_OPC, 5'b00000, legal no-op.

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  asynchronous active-low reset
enable  in  1  decode enable; 0 = hold state, emit bubble
instr_valid  in  1  fetched word valid this cycle
opcode  in  OPC_W  opcode field of fetched word
stall  in  1  hold pipeline register and FSM
flush  in  1  discard in-flight decode, insert bubble
ctl_valid  out  1  bundle valid
alu_op  out  OPC_W  ALU operation (= accepted opcode)
reg_wr  out  1  register write
mem_rd  out  1  memory read
mem_wr  out  1  memory write
alu_src  out  1  ALU B operand from immediate
ldm  out  1  load-immediate writeback select
imm_take  out  1  current fetched word consumed as immediate
busy  out  1  FSM in IMM state
illegal  out  1  one-cycle pulse, undefined opcode decoded

Behaviour:
- Reset (rst_n=0, async): all outputs 0, FSM=DECODE. Immediate on assertion, including mid-LDM sequence; pending immediate discarded.
- All outputs except imm_take and busy are registered: bundle appears the cycle after the word is accepted. imm_take is combinational from state and instr_valid. busy = (state==IMM).
- Accept condition: instr_valid & enable & ~stall & ~flush.
- Priority per edge: flush > stall > enable=0 > normal.
- flush: ctl_valid and all controls cleared next cycle; FSM -> DECODE; no illegal pulse.
- stall (no flush): all registered outputs and FSM hold their values.
- enable=0 or instr_valid=0 (no stall/flush): bubble (ctl_valid=0, controls 0, alu_op 0); FSM holds.
- DECODE, accepted word:
  - LDM_OPC: emit bubble; -> IMM. No bundle yet.
  - ST_OPC: mem_wr=1.
  - LD_OPC: mem_rd=1, reg_wr=1.
  - ALU1_OPC, ALU2_OPC: reg_wr=1.
  - NOP_OPC: ctl_valid=1, all controls 0.
  - Any other value, including nonzero bits above bit 4: ctl_valid=1, all controls 0, illegal=1 for one cycle.
  - ctl_valid=1 and alu_op=opcode for every non-LDM accepted word.
- IMM, accepted word: the word is not decoded, and imm_take=1 that cycle. Next cycle: ctl_valid=1, alu_op=LDM_OPC, alu_src=1, ldm=1, reg_wr=1, mem_rd=0, mem_wr=0. FSM -> DECODE.
- IMM with no accepted word: stay in IMM; bubble output.
- Back-to-back LDM pairs are legal with no extra bubbles beyond the first word.
- Illegal-opcode words never enter IMM.

Optional Feature:
CU_PERF_COUNT_EN. When defined:
- Adds outputs issue_cnt[31:0] and bubble_cnt[31:0], reset to 0.
- issue_cnt increments each cycle ctl_valid is registered 1; bubble_cnt increments each non-stall cycle ctl_valid is registered 0.
- Both counters wrap at 2^32 and hold during stall.
When undefined: neither port nor the counter logic exists.

Test Plan:
- Reset: rst_n=0 asynchronously mid-IMM -> all outputs 0 and busy=0 before the next clk edge; first word after release decodes in DECODE.
- Opcode stream 00011, 00010, 00101, 00000 with instr_valid=1 -> one cycle later: reg_wr=1; then mem_wr=1; then mem_rd=1 with reg_wr=1; then NOP with ctl_valid=1 and all controls 0.
- LDM: 00001 then immediate word 0x1F -> cycle+1 bubble with busy=1; imm_take=1 on the 0x1F cycle; cycle+2 alu_src=ldm=reg_wr=1, alu_op=00001.
- Stall and flush: stall=1 for 3 cycles during IMM -> outputs and busy held; flush=1 with stall=1 -> next cycle ctl_valid=0, busy=0.
- Illegal and enable: opcode 11111 -> illegal=1 for exactly one cycle, ctl_valid=1, controls 0; enable=0 with a valid LDM -> bubble, FSM stays in DECODE.
- CU_PERF_COUNT_EN defined: 10 issued words plus 1 LDM pair -> issue_cnt=11 and bubble_cnt=1.

Source files
------------

// File: rtl/pipelined_control_unit_if.sv
// rtl/pipelined_control_unit_if.sv - fetch-side inputs and ID/EX control bundle of the decode stage
// Optional perf counter signals exist only when CU_PERF_COUNT_EN is defined.
interface pipelined_control_unit_if #(
  parameter int OPC_W = 5
);
  logic             enable;
  logic             instr_valid;
  logic [OPC_W-1:0] opcode;
  logic             stall;
  logic             flush;
  logic             ctl_valid;
  logic [OPC_W-1:0] alu_op;
  logic             reg_wr;
  logic             mem_rd;
  logic             mem_wr;
  logic             alu_src;
  logic             ldm;
  logic             imm_take;
  logic             busy;
  logic             illegal;
`ifdef CU_PERF_COUNT_EN
  logic [31:0]      issue_cnt;
  logic [31:0]      bubble_cnt;

  modport slave (
    input  enable, instr_valid, opcode, stall, flush,
    output ctl_valid, alu_op, reg_wr, mem_rd, mem_wr, alu_src, ldm,
           imm_take, busy, illegal, issue_cnt, bubble_cnt
  );
  modport master (
    output enable, instr_valid, opcode, stall, flush,
    input  ctl_valid, alu_op, reg_wr, mem_rd, mem_wr, alu_src, ldm,
           imm_take, busy, illegal, issue_cnt, bubble_cnt
  );
`else
  modport slave (
    input  enable, instr_valid, opcode, stall, flush,
    output ctl_valid, alu_op, reg_wr, mem_rd, mem_wr, alu_src, ldm,
           imm_take, busy, illegal
  );
  modport master (
    output enable, instr_valid, opcode, stall, flush,
    input  ctl_valid, alu_op, reg_wr, mem_rd, mem_wr, alu_src, ldm,
           imm_take, busy, illegal
  );
`endif
endinterface

// File: rtl/pipelined_control_unit.sv
// rtl/pipelined_control_unit.sv - registered decode stage with two-word LDM sequencing FSM
// Define CU_PERF_COUNT_EN to add the issue/bubble performance counters.
module pipelined_control_unit #(
  parameter int               OPC_W    = 5,
  parameter logic [OPC_W-1:0] LDM_OPC  = OPC_W'(5'b00001),
  parameter logic [OPC_W-1:0] ST_OPC   = OPC_W'(5'b00010),
  parameter logic [OPC_W-1:0] LD_OPC   = OPC_W'(5'b00101),
  parameter logic [OPC_W-1:0] ALU1_OPC = OPC_W'(5'b00011),
  parameter logic [OPC_W-1:0] ALU2_OPC = OPC_W'(5'b00100),
  parameter logic [OPC_W-1:0] NOP_OPC  = OPC_W'(5'b00000)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  pipelined_control_unit_if.slave bus
);

  typedef enum logic {DECODE, IMM} state_t;

  typedef struct packed {
    logic             ctl_valid;
    logic [OPC_W-1:0] alu_op;
    logic             reg_wr;
    logic             mem_rd;
    logic             mem_wr;
    logic             alu_src;
    logic             ldm;
    logic             illegal;
  } ctl_t;

  state_t state_q, state_d;
  ctl_t   ctl_q, ctl_d;
  logic   accept;

  assign accept = bus.instr_valid & bus.enable & ~bus.stall & ~bus.flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= DECODE;
      ctl_q   <= '0;
    end else begin
      state_q <= state_d;
      ctl_q   <= ctl_d;
    end
  end

  // Bubble is the default; flush wins over stall, stall wins over a fresh decode.
  always_comb begin
    state_d = state_q;
    ctl_d   = '0;
    if (bus.flush) begin
      state_d = DECODE;
    end else if (bus.stall) begin
      ctl_d = ctl_q;
    end else if (accept) begin
      if (state_q == IMM) begin
        ctl_d.ctl_valid = 1'b1;
        ctl_d.alu_op    = LDM_OPC;
        ctl_d.alu_src   = 1'b1;
        ctl_d.ldm       = 1'b1;
        ctl_d.reg_wr    = 1'b1;
        state_d         = DECODE;
      end else if (bus.opcode == LDM_OPC) begin
        state_d = IMM;
      end else begin
        ctl_d.ctl_valid = 1'b1;
        ctl_d.alu_op    = bus.opcode;
        case (bus.opcode)
          ST_OPC:             ctl_d.mem_wr = 1'b1;
          LD_OPC: begin
            ctl_d.mem_rd = 1'b1;
            ctl_d.reg_wr = 1'b1;
          end
          ALU1_OPC, ALU2_OPC: ctl_d.reg_wr = 1'b1;
          NOP_OPC:            ctl_d.reg_wr = 1'b0;
          default:            ctl_d.illegal = 1'b1;
        endcase
      end
    end
  end

  assign bus.ctl_valid = ctl_q.ctl_valid;
  assign bus.alu_op    = ctl_q.alu_op;
  assign bus.reg_wr    = ctl_q.reg_wr;
  assign bus.mem_rd    = ctl_q.mem_rd;
  assign bus.mem_wr    = ctl_q.mem_wr;
  assign bus.alu_src   = ctl_q.alu_src;
  assign bus.ldm       = ctl_q.ldm;
  assign bus.illegal   = ctl_q.illegal;
  assign bus.busy      = (state_q == IMM);
  assign bus.imm_take  = (state_q == IMM) & accept;

`ifdef CU_PERF_COUNT_EN
  logic [31:0] issue_cnt_q, bubble_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else if (bus.flush || !bus.stall) begin
      if (ctl_d.ctl_valid) issue_cnt_q  <= issue_cnt_q + 32'd1;
      else                 bubble_cnt_q <= bubble_cnt_q + 32'd1;
    end
  end

  assign bus.issue_cnt  = issue_cnt_q;
  assign bus.bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_pipelined_control_unit.sv
// tb/tb_pipelined_control_unit.sv - directed self-checking bench for pipelined_control_unit
// Control flag packing used in checks: reg_wr=0x20 mem_rd=0x10 mem_wr=0x08 alu_src=0x04 ldm=0x02 illegal=0x01.
module tb_pipelined_control_unit;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  pipelined_control_unit_if #(.OPC_W(5)) bus ();

  pipelined_control_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ctl();
    return {26'd0, bus.reg_wr, bus.mem_rd, bus.mem_wr, bus.alu_src, bus.ldm, bus.illegal};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] opc);
    bus.instr_valid = v;
    bus.opcode      = opc;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.enable = 1'b1;
    bus.stall  = 1'b0;
    bus.flush  = 1'b0;
    drive(1'b0, 5'd0);
    #12;
    chk("rst_valid", 32'(bus.ctl_valid), 0);
    chk("rst_ctl", ctl(), 0);
    chk("rst_aluop", 32'(bus.alu_op), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    rst_n = 1'b1;

    // Plain decode stream
    drive(1'b1, 5'b00011); tick();
    chk("alu1_valid", 32'(bus.ctl_valid), 1);
    chk("alu1_ctl", ctl(), 'h20);
    chk("alu1_op", 32'(bus.alu_op), 'h03);
    drive(1'b1, 5'b00010); tick();
    chk("st_ctl", ctl(), 'h08);
    chk("st_op", 32'(bus.alu_op), 'h02);
    drive(1'b1, 5'b00101); tick();
    chk("ld_ctl", ctl(), 'h30);
    drive(1'b1, 5'b00000); tick();
    chk("nop_valid", 32'(bus.ctl_valid), 1);
    chk("nop_ctl", ctl(), 0);
    chk("nop_op", 32'(bus.alu_op), 0);
    drive(1'b1, 5'b00100); tick();
    chk("alu2_ctl", ctl(), 'h20);

    // LDM pair then a second back-to-back pair
    drive(1'b1, 5'b00001); tick();
    chk("ldm1_valid", 32'(bus.ctl_valid), 0);
    chk("ldm1_busy", 32'(bus.busy), 1);
    drive(1'b1, 5'h1F); #1;
    chk("ldm_immtake", 32'(bus.imm_take), 1);
    tick();
    chk("ldm2_valid", 32'(bus.ctl_valid), 1);
    chk("ldm2_ctl", ctl(), 'h26);
    chk("ldm2_op", 32'(bus.alu_op), 'h01);
    chk("ldm2_busy", 32'(bus.busy), 0);
    drive(1'b1, 5'b00001); tick();
    chk("b2b_busy", 32'(bus.busy), 1);
    drive(1'b1, 5'h00); tick();
    chk("b2b_ctl", ctl(), 'h26);
    drive(1'b1, 5'b00011); tick();
    chk("after_ldm_ctl", ctl(), 'h20);
    chk("after_ldm_take", 32'(bus.imm_take), 0);

    // Stall holds a live bundle
    drive(1'b1, 5'b00101); tick();
    bus.stall = 1'b1;
    drive(1'b1, 5'b00011); tick();
    chk("stall_hold_ctl", ctl(), 'h30);
    chk("stall_hold_op", 32'(bus.alu_op), 'h05);
    bus.stall = 1'b0;

    // Stall during IMM for three cycles, then flush with stall
    drive(1'b1, 5'b00001); tick();
    bus.stall = 1'b1;
    drive(1'b1, 5'h1F); #1;
    chk("stall_immtake", 32'(bus.imm_take), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_imm_busy", 32'(bus.busy), 1);
      chk("stall_imm_valid", 32'(bus.ctl_valid), 0);
    end
    bus.flush = 1'b1;
    tick();
    chk("flush_valid", 32'(bus.ctl_valid), 0);
    chk("flush_busy", 32'(bus.busy), 0);
    bus.flush = 1'b0;
    bus.stall = 1'b0;
    drive(1'b1, 5'b00011); tick();
    chk("post_flush_ctl", ctl(), 'h20);
    chk("post_flush_op", 32'(bus.alu_op), 'h03);

    // Flush clears a live bundle
    drive(1'b1, 5'b00010); tick();
    bus.flush = 1'b1;
    drive(1'b1, 5'b00011); tick();
    chk("flush_clr_valid", 32'(bus.ctl_valid), 0);
    chk("flush_clr_ctl", ctl(), 0);
    bus.flush = 1'b0;

    // Illegal opcode pulses once and never enters IMM
    drive(1'b1, 5'b11111); tick();
    chk("ill_valid", 32'(bus.ctl_valid), 1);
    chk("ill_ctl", ctl(), 'h01);
    chk("ill_op", 32'(bus.alu_op), 'h1F);
    chk("ill_busy", 32'(bus.busy), 0);
    drive(1'b1, 5'b00000); tick();
    chk("ill_pulse_end", ctl(), 0);

    // enable=0 with LDM, then instr_valid=0
    bus.enable = 1'b0;
    drive(1'b1, 5'b00001); tick();
    chk("en0_valid", 32'(bus.ctl_valid), 0);
    chk("en0_busy", 32'(bus.busy), 0);
    bus.enable = 1'b1;
    drive(1'b1, 5'b00011); tick();
    chk("en1_ctl", ctl(), 'h20);
    drive(1'b0, 5'b00010); tick();
    chk("iv0_valid", 32'(bus.ctl_valid), 0);
    chk("iv0_ctl", ctl(), 0);

    // Asynchronous reset mid-IMM and with a live bundle
    drive(1'b1, 5'b00001); tick();
    chk("pre_rst_busy", 32'(bus.busy), 1);
    drive(1'b1, 5'h1F);
    #2; rst_n = 1'b0; #1;
    chk("arst_busy", 32'(bus.busy), 0);
    chk("arst_take", 32'(bus.imm_take), 0);
    #1; rst_n = 1'b1;
    drive(1'b1, 5'b00101); tick();
    chk("rel_ctl", ctl(), 'h30);
    chk("rel_busy", 32'(bus.busy), 0);
    drive(1'b1, 5'b00011); tick();
    #2; rst_n = 1'b0; #1;
    chk("arst_live_valid", 32'(bus.ctl_valid), 0);
    chk("arst_live_ctl", ctl(), 0);
    chk("arst_live_op", 32'(bus.alu_op), 0);

`ifdef CU_PERF_COUNT_EN
    chk("cnt_rst_issue", bus.issue_cnt, 0);
    chk("cnt_rst_bubble", bus.bubble_cnt, 0);
    #1; rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 5'b00011); tick();
    end
    drive(1'b1, 5'b00001); tick();
    drive(1'b1, 5'h1F); tick();
    chk("cnt_issue", bus.issue_cnt, 11);
    chk("cnt_bubble", bus.bubble_cnt, 1);
`else
    #1; rst_n = 1'b1;
`endif

    drive(1'b0, 5'd0);
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
